// File: rtl/fir_pkg.sv
// Shared constants and the round-half-up / saturate helper for the FIR output scaler.
package fir_pkg;

    localparam int unsigned FIR_IN_W  = 32;
    localparam int unsigned FIR_OUT_W = 16;
    localparam int unsigned FIR_SHIFT = 15;
    localparam int unsigned SAT_CNT_W = 16;

    typedef struct packed {
        logic [FIR_IN_W:0] y;
        logic              sat;
    } fir_rs_t;

    // The 33-bit sum cannot overflow, so the clamp sees the true rounded value.
    function automatic fir_rs_t fir_round_sat(input logic [FIR_IN_W-1:0] x,
                                              input int unsigned         shift,
                                              input int unsigned         out_w);
        logic signed [FIR_IN_W:0] sum;
        logic signed [FIR_IN_W:0] q;
        logic signed [FIR_IN_W:0] hi;
        logic signed [FIR_IN_W:0] lo;
        fir_rs_t                  r;
        sum   = $signed({x[FIR_IN_W-1], x}) + (33'sd1 <<< (shift - 1));
        q     = sum >>> shift;
        hi    = (33'sd1 <<< (out_w - 1)) - 33'sd1;
        lo    = -(33'sd1 <<< (out_w - 1));
        r.y   = q;
        r.sat = 1'b0;
        if (q > hi) begin
            r.y   = hi;
            r.sat = 1'b1;
        end else if (q < lo) begin
            r.y   = lo;
            r.sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_skid_buffer.sv
// Output register plus one-entry skid register; ready is registered and means "skid empty".
module fir_skid_buffer #(
    parameter int unsigned W = 18
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         ready_q, ready_d;
    logic         accept;
    logic         out_free;

    always_comb begin
        accept       = in_valid_i & ready_q;
        out_free     = ~out_valid_q | out_ready_i;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (out_free) begin
            // A full skid always has priority: ready was low, so nothing new arrives this cycle.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                out_data_d  = accept ? in_data_i : '0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
        end
        ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            ready_q      <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            ready_q      <= ready_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

endmodule

// File: rtl/fir_out_scaler.sv
// Scales each 32-bit FIR word by a rounding right shift, saturates to OUT_W bits, counts clips.
module fir_out_scaler
    import fir_pkg::*;
#(
    parameter int unsigned SHIFT = FIR_SHIFT,
    parameter int unsigned OUT_W = FIR_OUT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [FIR_IN_W-1:0]  s_axis_fir_tdata,
    input  logic [3:0]           s_axis_fir_tkeep,
    input  logic                 s_axis_fir_tlast,
    input  logic                 s_axis_fir_tvalid,
    output logic                 s_axis_fir_tready,
    output logic [OUT_W-1:0]     m_axis_fir_tdata,
    output logic [OUT_W/8-1:0]   m_axis_fir_tkeep,
    output logic                 m_axis_fir_tlast,
    output logic                 m_axis_fir_tvalid,
    input  logic                 m_axis_fir_tready,
    input  logic                 sat_clear,
    output logic [SAT_CNT_W-1:0] sat_count
);

    localparam int unsigned PW = OUT_W + 2;

    fir_rs_t              rs;
    logic                 s_accept;
    logic [PW-1:0]        in_payload;
    logic [PW-1:0]        out_payload;
    logic [SAT_CNT_W-1:0] sat_count_q, sat_count_d;

    // Upper result bits are sign copies after the clamp; the sat flag rides along with each beat.
    logic unused_tkeep;
    logic unused_rs_hi;
    logic unused_out_sat;

    assign rs         = fir_round_sat(s_axis_fir_tdata, SHIFT, OUT_W);
    assign s_accept   = s_axis_fir_tvalid & s_axis_fir_tready;
    assign in_payload = {rs.sat, s_axis_fir_tlast, rs.y[OUT_W-1:0]};

    fir_skid_buffer #(
        .W (PW)
    ) u_skid (
        .clk_i       (clk),
        .rst_ni      (reset),
        .in_valid_i  (s_axis_fir_tvalid),
        .in_ready_o  (s_axis_fir_tready),
        .in_data_i   (in_payload),
        .out_valid_o (m_axis_fir_tvalid),
        .out_ready_i (m_axis_fir_tready),
        .out_data_o  (out_payload)
    );

    assign m_axis_fir_tdata = out_payload[OUT_W-1:0];
    assign m_axis_fir_tlast = out_payload[OUT_W];
    assign m_axis_fir_tkeep = {(OUT_W/8){m_axis_fir_tvalid}};

    assign unused_tkeep   = ^s_axis_fir_tkeep;
    assign unused_rs_hi   = ^rs.y[FIR_IN_W:OUT_W];
    assign unused_out_sat = out_payload[OUT_W+1];

    always_comb begin
        sat_count_d = sat_count_q;
        if (sat_clear) begin
            sat_count_d = '0;
        end else if (s_accept && rs.sat && (sat_count_q != {SAT_CNT_W{1'b1}})) begin
            sat_count_d = sat_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_count_q <= '0;
        end else begin
            sat_count_q <= sat_count_d;
        end
    end

    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_fir_out_scaler.sv
// Randomised bench for fir_out_scaler against an arithmetic reference model.
module tb_fir_out_scaler;

    localparam int unsigned SHIFT = 15;
    localparam int unsigned OUT_W = 16;

    logic        clk;
    logic        reset;
    logic [31:0] s_data;
    logic [3:0]  s_keep;
    logic        s_last;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] m_data;
    logic [1:0]  m_keep;
    logic        m_last;
    logic        m_valid;
    logic        m_ready;
    logic        sat_clear;
    logic [15:0] sat_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] stim_d[$];
    bit          stim_l[$];
    logic [16:0] out_q[$];
    bit          rdy_tr[$];
    int          cyc_used;
    int          first_out;
    logic [15:0] sat_model = 16'h0;

    logic [15:0] prev_data;
    logic        prev_last;
    logic        prev_stall;
    int          stab_err = 0;
    int          keep_err = 0;

    fir_out_scaler #(
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .s_axis_fir_tdata  (s_data),
        .s_axis_fir_tkeep  (s_keep),
        .s_axis_fir_tlast  (s_last),
        .s_axis_fir_tvalid (s_valid),
        .s_axis_fir_tready (s_ready),
        .m_axis_fir_tdata  (m_data),
        .m_axis_fir_tkeep  (m_keep),
        .m_axis_fir_tlast  (m_last),
        .m_axis_fir_tvalid (m_valid),
        .m_axis_fir_tready (m_ready),
        .sat_clear         (sat_clear),
        .sat_count         (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Collects output transfers and watches hold-while-stalled and tkeep behaviour.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (m_valid && m_ready) out_q.push_back({m_last, m_data});
            if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last))
                stab_err <= stab_err + 1;
            if (m_keep !== {2{m_valid}}) keep_err <= keep_err + 1;
            prev_stall <= m_valid && !m_ready;
            prev_data  <= m_data;
            prev_last  <= m_last;
        end
    end

    // Reference: y = floor((x + 2^(SHIFT-1)) / 2^SHIFT), clamped; returns {sat, y}.
    function automatic logic [16:0] ref_beat(input logic [31:0] x);
        longint v, div, t, q;
        bit     sat;
        v   = longint'($signed(x));
        div = longint'(1) << SHIFT;
        t   = v + div / 2;
        q   = t / div;
        if ((t % div) != 0 && t < 0) q = q - 1;
        sat = 1'b0;
        if (q > 32767) begin
            q   = 32767;
            sat = 1'b1;
        end else if (q < -32768) begin
            q   = -32768;
            sat = 1'b1;
        end
        return {sat, q[15:0]};
    endfunction

    function automatic logic [31:0] gen_x();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       return r;
            1:       return {{2{r[31]}}, r[29:0]};
            2:       return (r[31] ? 32'h3FFF8000 : 32'hC0000000) + $urandom_range(0, 65535)
                            - 32'd32768;
            default: return {{16{r[31]}}, r[15:0]};
        endcase
    endfunction

    function automatic logic [31:0] gen_sat();
        logic [31:0] r;
        r = $urandom;
        return r[0] ? (32'h40000000 | (r & 32'h3FFFFFFF)) : (32'h80000000 | (r & 32'h3FFE0000));
    endfunction

    task automatic model_sat(input int clr_idx);
        logic [16:0] e;
        for (int i = 0; i < stim_d.size(); i++) begin
            e = ref_beat(stim_d[i]);
            if (i == clr_idx) sat_model = 16'h0;
            else if (e[16] && sat_model != 16'hFFFF) sat_model = sat_model + 16'h1;
        end
    endtask

    // Streams stim_d/stim_l through the DUT; inputs change 1 time unit after each rising edge.
    task automatic run_stream(input int valid_pct, input int ready_pct, input int stall_from,
                              input int stall_len, input int clr_idx);
        int idx;
        int cyc;
        int n;
        int limit;
        bit acc;
        idx   = 0;
        cyc   = 0;
        n     = stim_d.size();
        limit = 20 * n + 200;
        out_q.delete();
        rdy_tr.delete();
        first_out = -1;
        while (out_q.size() < n && cyc < limit) begin
            s_valid   = (idx < n) && ($urandom_range(1, 100) <= valid_pct);
            s_data    = (idx < n) ? stim_d[idx] : 32'h0;
            s_last    = (idx < n) ? stim_l[idx] : 1'b0;
            s_keep    = 4'($urandom);
            m_ready   = ($urandom_range(1, 100) <= ready_pct) &&
                        !(cyc >= stall_from && cyc < stall_from + stall_len);
            sat_clear = (idx == clr_idx) && s_valid && s_ready;
            rdy_tr.push_back(s_ready);
            if (first_out < 0 && m_valid) first_out = cyc;
            acc = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            cyc++;
        end
        s_valid   = 1'b0;
        s_last    = 1'b0;
        sat_clear = 1'b0;
        m_ready   = 1'b1;
        cyc_used  = cyc;
        checks++;
        if (cyc >= limit) begin
            errors++;
            $display("FAIL stream_timeout got %0d of %0d beats after %0d cycles",
                     out_q.size(), n, cyc);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        s_valid   = 1'b0;
        s_data    = 32'h0;
        s_keep    = 4'h0;
        s_last    = 1'b0;
        m_ready   = 1'b1;
        sat_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 6;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b want 0", m_valid); end
        if (m_data !== 16'h0) begin errors++; $display("FAIL rst_tdata got %h want 0", m_data); end
        if (m_keep !== 2'b00) begin errors++; $display("FAIL rst_tkeep got %b want 00", m_keep); end
        if (m_last !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b want 0", m_last); end
        if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_tready got %b want 0", s_ready); end
        if (sat_count !== 16'h0) begin
            errors++; $display("FAIL rst_satcnt got %h want 0", sat_count);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++; $display("FAIL rel_tready_early got %b want 0", s_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL rel_tready got %b want 1", s_ready); end
    endtask

    task automatic test_vectors();
        logic [15:0] exp_a[3];
        logic [15:0] exp_b[3];
        exp_a = '{16'h0001, 16'h0000, 16'h0000};
        exp_b = '{16'h7FFF, 16'h8000, 16'h7FFF};
        stim_d = '{32'h00004000, 32'h00003FFF, 32'hFFFFC000};
        stim_l = '{1'b0, 1'b0, 1'b1};
        run_stream(100, 100, -100, 0, -1);
        model_sat(-1);
        checks += 2;
        if (first_out !== 1) begin errors++; $display("FAIL latency got %0d want 1", first_out); end
        if (out_q.size() != 3) begin
            errors++; $display("FAIL vec_a_count got %0d want 3", out_q.size());
        end
        for (int i = 0; i < 3 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i][15:0] !== exp_a[i]) begin
                errors++; $display("FAIL vec_a_%0d got %h want %h", i, out_q[i][15:0], exp_a[i]);
            end
        end
        checks++;
        if (sat_count !== 16'h0) begin
            errors++; $display("FAIL vec_a_satcnt got %h want 0", sat_count);
        end
        stim_d = '{32'h40000000, 32'hC0000000, 32'h3FFF8000};
        stim_l = '{1'b0, 1'b0, 1'b1};
        run_stream(100, 100, -100, 0, -1);
        model_sat(-1);
        for (int i = 0; i < 3 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i][15:0] !== exp_b[i]) begin
                errors++; $display("FAIL vec_b_%0d got %h want %h", i, out_q[i][15:0], exp_b[i]);
            end
        end
        checks++;
        if (sat_count !== 16'h1) begin
            errors++; $display("FAIL vec_b_satcnt got %h want 1", sat_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] e;
        int          lows;
        stim_d.delete();
        stim_l.delete();
        for (int i = 0; i < 16; i++) begin
            stim_d.push_back(gen_x());
            stim_l.push_back(i == 15);
        end
        run_stream(100, 100, -100, 0, -1);
        model_sat(-1);
        lows = 0;
        foreach (rdy_tr[i]) if (!rdy_tr[i]) lows++;
        checks += 3;
        if (cyc_used != 17) begin errors++; $display("FAIL b2b_cycles got %0d want 17", cyc_used); end
        if (lows != 0) begin errors++; $display("FAIL b2b_ready_low got %0d want 0", lows); end
        if (sat_count !== sat_model) begin
            errors++; $display("FAIL b2b_satcnt got %h want %h", sat_count, sat_model);
        end
        for (int i = 0; i < stim_d.size() && i < out_q.size(); i++) begin
            e = ref_beat(stim_d[i]);
            checks++;
            if (out_q[i] !== {stim_l[i], e[15:0]}) begin
                errors++;
                $display("FAIL b2b_beat_%0d got %h want %h", i, out_q[i], {stim_l[i], e[15:0]});
            end
        end
    endtask

    task automatic test_random();
        logic [16:0] e;
        stim_d.delete();
        stim_l.delete();
        for (int i = 0; i < 300; i++) begin
            stim_d.push_back(gen_x());
            stim_l.push_back(($urandom_range(0, 7) == 0) || i == 299);
        end
        run_stream(70, 50, -100, 0, -1);
        model_sat(-1);
        checks += 4;
        if (out_q.size() != 300) begin
            errors++; $display("FAIL rnd_count got %0d want 300", out_q.size());
        end
        if (sat_count !== sat_model) begin
            errors++; $display("FAIL rnd_satcnt got %h want %h", sat_count, sat_model);
        end
        if (stab_err != 0) begin errors++; $display("FAIL rnd_stable got %0d want 0", stab_err); end
        if (keep_err != 0) begin errors++; $display("FAIL rnd_tkeep got %0d want 0", keep_err); end
        for (int i = 0; i < stim_d.size() && i < out_q.size(); i++) begin
            e = ref_beat(stim_d[i]);
            checks++;
            if (out_q[i] !== {stim_l[i], e[15:0]}) begin
                errors++;
                $display("FAIL rnd_beat_%0d got %h want %h", i, out_q[i], {stim_l[i], e[15:0]});
            end
        end
    endtask

    task automatic test_stall();
        logic [16:0] e;
        stim_d.delete();
        stim_l.delete();
        for (int i = 0; i < 20; i++) begin
            stim_d.push_back(gen_x());
            stim_l.push_back(i == 19);
        end
        run_stream(100, 100, 10, 3, -1);
        model_sat(-1);
        checks += 6;
        if (out_q.size() != 20) begin
            errors++; $display("FAIL stall_count got %0d want 20", out_q.size());
        end
        if (rdy_tr[10] !== 1'b1) begin errors++; $display("FAIL stall_rdy10 got %b want 1", rdy_tr[10]); end
        if (rdy_tr[11] !== 1'b0) begin errors++; $display("FAIL stall_rdy11 got %b want 0", rdy_tr[11]); end
        if (rdy_tr[13] !== 1'b0) begin errors++; $display("FAIL stall_rdy13 got %b want 0", rdy_tr[13]); end
        if (rdy_tr[14] !== 1'b1) begin errors++; $display("FAIL stall_rdy14 got %b want 1", rdy_tr[14]); end
        if (stab_err != 0) begin errors++; $display("FAIL stall_stable got %0d want 0", stab_err); end
        for (int i = 0; i < stim_d.size() && i < out_q.size(); i++) begin
            e = ref_beat(stim_d[i]);
            checks++;
            if (out_q[i] !== {stim_l[i], e[15:0]}) begin
                errors++;
                $display("FAIL stall_beat_%0d got %h want %h", i, out_q[i], {stim_l[i], e[15:0]});
            end
        end
    endtask

    task automatic test_sat_clear();
        stim_d.delete();
        stim_l.delete();
        for (int i = 0; i < 10; i++) begin
            stim_d.push_back(gen_sat());
            stim_l.push_back(i == 9);
        end
        run_stream(100, 100, -100, 0, 4);
        model_sat(4);
        checks++;
        if (sat_count !== 16'd5) begin
            errors++; $display("FAIL clr_satcnt got %0d want 5", sat_count);
        end
        stim_d.delete();
        stim_l.delete();
        for (int i = 0; i < 65530; i++) begin
            stim_d.push_back(gen_sat());
            stim_l.push_back(1'b0);
        end
        run_stream(100, 100, -100, 0, -1);
        model_sat(-1);
        checks += 2;
        if (out_q.size() != 65530) begin
            errors++; $display("FAIL fill_count got %0d want 65530", out_q.size());
        end
        if (sat_count !== 16'hFFFF) begin
            errors++; $display("FAIL fill_satcnt got %h want ffff", sat_count);
        end
        stim_d = '{gen_sat()};
        stim_l = '{1'b1};
        run_stream(100, 100, -100, 0, -1);
        model_sat(-1);
        checks++;
        if (sat_count !== 16'hFFFF) begin
            errors++; $display("FAIL hold_satcnt got %h want ffff", sat_count);
        end
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h40000000;
        s_last  = 1'b0;
        @(posedge clk);
        #1;
        s_data = 32'h80000000;
        s_last = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL mid_skidfull got %b want 0", s_ready); end
        #2;
        reset = 1'b0;
        #1;
        sat_model = 16'h0;
        checks += 3;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_tvalid got %b want 0", m_valid); end
        if (sat_count !== 16'h0) begin
            errors++; $display("FAIL mid_satcnt got %h want 0", sat_count);
        end
        if (s_ready !== 1'b0) begin errors++; $display("FAIL mid_tready got %b want 0", s_ready); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_ready = 1'b1;
        out_q.delete();
        @(posedge clk);
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL mid_rel_tready got %b want 1", s_ready);
        end
        repeat (8) @(posedge clk);
        #1;
        checks += 2;
        if (out_q.size() != 0) begin
            errors++; $display("FAIL mid_stale got %0d beats want 0", out_q.size());
        end
        if (sat_count !== sat_model) begin
            errors++; $display("FAIL mid_satcnt_after got %h want %h", sat_count, sat_model);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_random();
        test_stall();
        test_sat_clear();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_out_scaler.md
FIR_OUT_SCALER -- requirements
Module: fir_out_scaler

Interface
REQ-001 Parameter SHIFT, default 15, SHALL set the arithmetic right-shift applied to each filter output word (legal range 1..30).
REQ-002 Parameter OUT_W, default 16, SHALL set the output sample width.
REQ-003 clk  input  1  SHALL be the single clock; all state is updated on the rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 s_axis_fir_tdata  input  32  SHALL carry the signed filter output word from dfilter.
REQ-006 s_axis_fir_tkeep  input  4  SHALL be accepted and ignored.
REQ-007 s_axis_fir_tlast  input  1  SHALL mark the last beat of a packet.
REQ-008 s_axis_fir_tvalid  input  1  SHALL flag a valid upstream beat.
REQ-009 s_axis_fir_tready  output  1  SHALL signal that the block can accept a beat.
REQ-010 m_axis_fir_tdata  output  OUT_W  SHALL carry the scaled, saturated signed sample.
REQ-011 m_axis_fir_tkeep  output  OUT_W/8  SHALL be all ones whenever m_axis_fir_tvalid is high, else zero.
REQ-012 m_axis_fir_tlast, m_axis_fir_tvalid  output  1 each  SHALL carry the standard AXI-Stream meanings.
REQ-013 m_axis_fir_tready  input  1  SHALL signal downstream acceptance.
REQ-014 sat_clear  input  1  SHALL synchronously clear sat_count.
REQ-015 sat_count  output  16  SHALL count the beats that were saturated.

Function
REQ-016 A beat SHALL transfer on either port only in a cycle with tvalid and tready both high.
REQ-017 Scaling SHALL be round-half-up: y = (x + 2^(SHIFT-1)) >>> SHIFT, computed at 33-bit signed width with no wrap.
REQ-018 y > 2^(OUT_W-1)-1 SHALL output 0x7FFF; y < -2^(OUT_W-1) SHALL output 0x8000; either case SHALL be flagged as saturated.
REQ-019 An accepted beat SHALL appear on the m_axis port on the next cycle (latency 1) when the output register is free or is being drained.
REQ-020 The datapath SHALL be an output register plus a one-entry skid register; s_axis_fir_tready SHALL be registered and equal to "skid empty".
REQ-021 If the output is stalled (m_tvalid=1, m_tready=0) when a beat is accepted, the beat SHALL go into the skid register and s_axis_fir_tready SHALL fall on the next cycle.
REQ-022 When the output drains with the skid full, the skid contents SHALL move to the output register and s_axis_fir_tready SHALL rise on the next cycle.
REQ-023 No beat SHALL be dropped or duplicated; order, tlast and saturation status SHALL travel with each beat.
REQ-024 m_axis signals SHALL stay stable while m_tvalid=1 and m_tready=0.
REQ-025 Accepting a beat while the output register drains in the same cycle SHALL sustain one beat per cycle.
REQ-026 sat_count SHALL increment by one when a saturated beat is accepted on s_axis, and SHALL hold at 0xFFFF (no wrap).
REQ-027 If sat_clear and a saturated accept occur in the same cycle, clear SHALL win and sat_count SHALL become 0.

Reset
REQ-028 While reset=0: m_axis_fir_tvalid=0, tdata=0, tkeep=0, tlast=0, s_axis_fir_tready=0, sat_count=0, and the skid register SHALL be empty.
REQ-029 s_axis_fir_tready SHALL go to 1 on the first clock edge after reset deasserts.
REQ-030 A reset asserted mid-stream SHALL discard any beats held in the output and skid registers.

Structure
REQ-031 The shared package fir_pkg SHALL hold the FIR_IN_W=32 and FIR_OUT_W=16 constants, the SHIFT default, and the round/saturate function.
REQ-032 The skid logic SHALL be a sub-module fir_skid_buffer, parameterised by payload width (OUT_W+2: data, tlast, sat flag).

Verification
REQ-033 SHIFT=15, inputs 0x00004000, 0x00003FFF, 0xFFFFC000 -> outputs 0x0001, 0x0000, 0x0000; sat_count=0.
REQ-034 Inputs 0x40000000, 0xC0000000, 0x3FFF8000 -> outputs 0x7FFF (sat), 0x8000 (no sat), 0x7FFF (no sat); sat_count=1.
REQ-035 Continuous valid with m_tready low for 3 cycles from cycle 10 -> s_tready falls one cycle after the stall begins, all 20 beats arrive in order, tlast on beat 20 only.
REQ-036 Ten saturating beats with sat_clear pulsed during the 5th accept -> sat_count=5 at the end; with sat_count preset to 0xFFFF, one more saturating beat leaves it at 0xFFFF.
REQ-037 Reset pulsed low with the skid full -> m_tvalid=0 and sat_count=0 immediately, s_tready=1 one cycle after release, no stale beat emitted.
